// File: rtl/d1_ternary_seq_if.sv
// Handshake bundle for d1_ternary_seq: frame control, activation stream,
// weight ROM port and result stream.
interface d1_ternary_seq_if #(
    parameter int A_BW        = 8,
    parameter int D1_BW_W     = 2,
    parameter int LOG2_D1_CYC = 9,
    parameter int OUT_BW      = 8
);
    logic                    start;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_BW-1:0]  in_data;
    logic [LOG2_D1_CYC-1:0]  d1_cntr;
    logic [D1_BW_W-1:0]      dw_1;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_BW-1:0] out_data;
    logic                    w_err;

    modport master (
        output start, in_valid, in_data, dw_1, out_ready,
        input  busy, in_ready, d1_cntr, out_valid, out_data, w_err
    );
    modport slave (
        input  start, in_valid, in_data, dw_1, out_ready,
        output busy, in_ready, d1_cntr, out_valid, out_data, w_err
    );
endinterface

// File: rtl/d1_ternary_seq.sv
// Dense-1 ternary sequencer: walks the weight ROM, accumulates +/-/0 products.
// Define D1_SAT_EN to saturate the shifted result instead of wrapping it.
module d1_ternary_seq #(
    parameter int A_BW        = 8,
    parameter int D1_BW_W     = 2,
    parameter int LOG2_D1_CYC = 9,
    parameter int D1_CYC      = 512,
    parameter int D1_SHIFT    = 0,
    parameter int OUT_BW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    d1_ternary_seq_if.slave  bus
);
    localparam int ACC_BW = A_BW + LOG2_D1_CYC + 1;
    // one spare bit over the wider of acc/out so the saturation compare never wraps
    localparam int CMP_BW = ((ACC_BW > OUT_BW) ? ACC_BW : OUT_BW) + 1;
    localparam logic signed [CMP_BW-1:0] SAT_MAX = {{(CMP_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
    localparam logic signed [CMP_BW-1:0] SAT_MIN = {{(CMP_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                    state, state_nxt;
    logic signed [ACC_BW-1:0]  acc, a_ext, prod, acc_sum, acc_sh;
    logic signed [CMP_BW-1:0]  sh_ext;
    logic [OUT_BW-1:0]         out_red;
    logic [LOG2_D1_CYC-1:0]    cntr;
    logic signed [OUT_BW-1:0]  out_q;
    logic                      err_q, xfer, last;

    assign xfer = bus.in_valid && (state == ACC);
    assign last = (cntr == LOG2_D1_CYC'(D1_CYC - 1));

    always_comb begin
        a_ext = {{(ACC_BW-A_BW){bus.in_data[A_BW-1]}}, bus.in_data};
        prod  = '0;
        if (bus.dw_1 == D1_BW_W'(1))
            prod = a_ext;
        else if (bus.dw_1 == D1_BW_W'(3))
            prod = -a_ext;
    end

    assign acc_sum = acc + prod;
    assign acc_sh  = acc_sum >>> D1_SHIFT;
    assign sh_ext  = {{(CMP_BW-ACC_BW){acc_sh[ACC_BW-1]}}, acc_sh};

    always_comb begin
        out_red = sh_ext[OUT_BW-1:0];
`ifdef D1_SAT_EN
        if (sh_ext > SAT_MAX)
            out_red = SAT_MAX[OUT_BW-1:0];
        else if (sh_ext < SAT_MIN)
            out_red = SAT_MIN[OUT_BW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.busy      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = ACC;
            ACC: begin
                bus.busy     = 1'b1;
                bus.in_ready = 1'b1;
                if (xfer && last) state_nxt = OUT;
            end
            OUT: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cntr  <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            acc   <= '0;
            cntr  <= '0;
            err_q <= 1'b0;
        end else if (xfer) begin
            acc  <= acc_sum;
            cntr <= cntr + LOG2_D1_CYC'(1);
            if (bus.dw_1 == D1_BW_W'(2))
                err_q <= 1'b1;
            // result captured from the sum that already includes the final product
            if (last)
                out_q <= out_red;
        end
    end

    assign bus.d1_cntr  = cntr;
    assign bus.out_data = out_q;
    assign bus.w_err    = err_q;
endmodule

// File: tb/tb_d1_ternary_seq.sv
// Bench for d1_ternary_seq: an 8-bit-output and a full-width-output instance share
// one stimulus; a frame-level model predicts results from the ROM and data arrays.
module tb_d1_ternary_seq;
    localparam int N      = 512;
    localparam int SH     = 0;
    localparam int OW     = 8;
    localparam int ACC_BW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [7:0] in_data = '0;
    logic [1:0] rom [N];
    int fdata [N];
    int total = 0, bad = 0;
    int exp_sum = 0;
    int m_ph = 0, m_cnt = 0, m_out8 = 0, m_outw = 0, m_err = 0;

    d1_ternary_seq_if #(.A_BW(8), .D1_BW_W(2), .LOG2_D1_CYC(9), .OUT_BW(OW))     bus8();
    d1_ternary_seq_if #(.A_BW(8), .D1_BW_W(2), .LOG2_D1_CYC(9), .OUT_BW(ACC_BW)) busw();

    assign bus8.start = start;     assign busw.start = start;
    assign bus8.in_valid = in_valid; assign busw.in_valid = in_valid;
    assign bus8.in_data = in_data; assign busw.in_data = in_data;
    assign bus8.out_ready = out_ready; assign busw.out_ready = out_ready;
    assign bus8.dw_1 = rom[bus8.d1_cntr];
    assign busw.dw_1 = rom[busw.d1_cntr];

    d1_ternary_seq #(.A_BW(8), .D1_BW_W(2), .LOG2_D1_CYC(9), .D1_CYC(N), .D1_SHIFT(SH), .OUT_BW(OW))
        dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    d1_ternary_seq #(.A_BW(8), .D1_BW_W(2), .LOG2_D1_CYC(9), .D1_CYC(N), .D1_SHIFT(SH), .OUT_BW(ACC_BW))
        dutw (.clk(clk), .rst_n(rst_n), .bus(busw));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wv(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
    endfunction

    function automatic int frame_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += fdata[i] * wv(rom[i]);
        return s;
    endfunction

    function automatic int red8(input int s);
        int sh = s >>> SH;
`ifdef D1_SAT_EN
        if (sh > 127) return 127;
        if (sh < -128) return -128;
        return sh;
`else
        logic signed [7:0] t = sh[7:0];
        return int'(t);
`endif
    endfunction

    // transaction-level reference: phase, transfers seen, frame result
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_cnt <= 0; m_err <= 0; m_out8 <= 0; m_outw <= 0;
        end else if (m_ph == 0) begin
            if (start) begin m_ph <= 1; m_cnt <= 0; m_err <= 0; end
        end else if (m_ph == 1) begin
            if (in_valid) begin
                if (rom[m_cnt] == 2'b10) m_err <= 1;
                if (m_cnt == N - 1) begin
                    m_cnt <= 0; m_ph <= 2;
                    m_out8 <= red8(exp_sum); m_outw <= exp_sum >>> SH;
                end else m_cnt <= m_cnt + 1;
            end
        end else if (out_ready) m_ph <= 0;
    end

    always @(negedge clk) begin
        chk("busy", int'(bus8.busy), int'(m_ph != 0));
        chk("in_ready", int'(bus8.in_ready), int'(m_ph == 1));
        chk("out_valid", int'(bus8.out_valid), int'(m_ph == 2));
        chk("d1_cntr", int'(bus8.d1_cntr), m_cnt);
        chk("d1_cntr_w", int'(busw.d1_cntr), m_cnt);
        chk("out_data8", int'(bus8.out_data), m_out8);
        chk("out_data_w", int'(busw.out_data), m_outw);
        chk("w_err", int'(bus8.w_err), m_err);
        chk("out_valid_w", int'(busw.out_valid), int'(m_ph == 2));
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(bus8.busy), 0);
        chk({tag, "_in_ready"}, int'(bus8.in_ready), 0);
        chk({tag, "_out_valid"}, int'(bus8.out_valid), 0);
        chk({tag, "_out_data8"}, int'(bus8.out_data), 0);
        chk({tag, "_out_data_w"}, int'(busw.out_data), 0);
        chk({tag, "_d1_cntr"}, int'(bus8.d1_cntr), 0);
        chk({tag, "_w_err"}, int'(bus8.w_err), 0);
    endtask

    task automatic fill_rand(input bit allow_bad, input int dmin, input int dmax);
        for (int i = 0; i < N; i++) begin
            int c;
            fdata[i] = int'($urandom_range(dmax - dmin)) + dmin;
            c = int'($urandom_range(3));
            if (!allow_bad && c == 2) c = 3;
            rom[i] = 2'(c);
        end
    endtask

    task automatic run_frame(input int duty, input int stall);
        int idx, guard;
        int h8, hw;
        exp_sum = frame_sum();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idx = 0; guard = 0;
        while (idx < N && guard < 20000) begin
            in_valid = ($urandom_range(99) < duty);
            in_data  = 8'(fdata[idx]);
            start    = (idx == 100);
            @(posedge clk);
            if (in_valid) idx++;
            #1 guard++;
        end
        in_valid = 1'b0; start = 1'b0;
        chk("frame_done", idx, N);
        chk("latency_valid", int'(bus8.out_valid), 1);
        h8 = int'(bus8.out_data); hw = int'(busw.out_data);
        repeat (stall) begin
            start = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", int'(bus8.out_valid), 1);
            chk("stall_data8", int'(bus8.out_data), h8);
            chk("stall_data_w", int'(busw.out_data), hw);
            chk("stall_busy", int'(bus8.busy), 1);
        end
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk("accept_valid", int'(bus8.out_valid), 0);
        chk("accept_busy", int'(bus8.busy), 0);
        chk("accept_hold8", int'(bus8.out_data), h8);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin rom[i] = 2'b01; fdata[i] = 1; end
        #2 rst_n = 1'b0;
        #1 check_reset_vals("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // all +1, data 1
        run_frame(100, 0);
`ifdef D1_SAT_EN
        chk("f1_out8", int'(bus8.out_data), 127);
`else
        chk("f1_out8", int'(bus8.out_data), 0);
`endif
        chk("f1_outw", int'(busw.out_data), 512);

        // alternating +1/-1, data 5, held result
        for (int i = 0; i < N; i++) begin rom[i] = (i % 2 == 0) ? 2'b01 : 2'b11; fdata[i] = 5; end
        run_frame(100, 10);
        chk("f2_out8", int'(bus8.out_data), 0);
        chk("f2_w_err", int'(bus8.w_err), 0);

        // all -1, most negative data
        for (int i = 0; i < N; i++) begin rom[i] = 2'b11; fdata[i] = -128; end
        run_frame(100, 1);
        chk("f3_outw", int'(busw.out_data), 65536);
`ifdef D1_SAT_EN
        chk("f3_out8", int'(bus8.out_data), 127);
`else
        chk("f3_out8", int'(bus8.out_data), 0);
`endif

        // illegal code at index 7 contributes nothing
        for (int i = 0; i < N; i++) begin rom[i] = 2'b01; fdata[i] = 1; end
        rom[7] = 2'b10;
        run_frame(100, 2);
        chk("f4_outw", int'(busw.out_data), 511);
        chk("f4_w_err", int'(bus8.w_err), 1);
`ifdef D1_SAT_EN
        chk("f4_out8", int'(bus8.out_data), 127);
`else
        chk("f4_out8", int'(bus8.out_data), -1);
`endif

        // next start clears the sticky error
        fill_rand(1'b0, -128, 127);
        run_frame(30, int'($urandom_range(4)));
        chk("f5_w_err_clr", int'(bus8.w_err), 0);

        for (int f = 0; f < 3; f++) begin
            fill_rand(1'b1, -128, 127);
            run_frame(30, int'($urandom_range(6)));
        end
        fill_rand(1'b1, -3, 3);
        run_frame(70, 0);

        // reset after 200 transfers
        fill_rand(1'b1, -128, 127);
        rom[7] = 2'b10;
        exp_sum = frame_sum();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1; in_data = 8'(fdata[i]);
            @(posedge clk); #1;
        end
        chk("pre_rst_cntr", int'(bus8.d1_cntr), 200);
        chk("pre_rst_w_err", int'(bus8.w_err), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid");
        in_valid = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("no_start_idle", int'(bus8.busy), 0);
        fill_rand(1'b1, -128, 127);
        run_frame(100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1);
    end
endmodule
